// File: rtl/flappy_pipe_engine.sv
// Pipe-obstacle engine: scrolling pipe pairs with LFSR gaps, per-pixel pipe mask, score and game FSM.
// Optional collision logic (hit latch, RUN->HIT) is built only when PIPE_COLLIDE_EN is defined.
module flappy_pipe_engine #(
   parameter int NUM_PIPES    = 3,
   parameter int PIPE_WIDTH   = 70,
   parameter int PIPE_SPACING = 250,
   parameter int GAP_MIN      = 120,
   parameter int TOP_MIN      = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [2:0]  address,
   input  logic [7:0]  writedata,
   output logic [7:0]  readdata,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        blank_n,
   input  logic        frame_tick,
   input  logic [9:0]  bird_x,
   input  logic        bird_pix,
   output logic        pipe_pix,
   output logic [1:0]  state,
   output logic [15:0] score
);

   // state   | meaning
   // IDLE    | pipes parked at the init set, no motion
   // RUN     | pipes scroll by speed on every frame_tick
   // HIT     | bird touched a pipe, everything frozen until start/stop
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HIT = 2'd2} state_t;

   localparam logic signed [12:0] PW13 = 13'(PIPE_WIDTH);

   function automatic logic [11:0] init_xr(input int i);
      return 12'(640 + PIPE_WIDTH + i * PIPE_SPACING);
   endfunction

   function automatic logic [9:0] init_gap_top(input int i);
      return 10'(TOP_MIN + ((64 * i) % 256));
   endfunction

   state_t        state_q, state_d;
   logic [15:0]   score_q, score_d;
   logic [2:0]    speed_q, speed_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [7:0]    readdata_q, readdata_d;
   logic [11:0]   xr_q [NUM_PIPES];
   logic [11:0]   xr_d [NUM_PIPES];
   logic [9:0]    gap_top_q [NUM_PIPES];
   logic [9:0]    gap_top_d [NUM_PIPES];
   logic [9:0]    gap_h_q [NUM_PIPES];
   logic [9:0]    gap_h_d [NUM_PIPES];

   logic          wr_en;
   logic          tick_run;
   logic          do_init;
   logic          move_en;
   logic          crossed;
   logic          pix;
   logic [15:0]   r;
   logic signed [12:0] left_old, left_new, bird_s, px_left, col_s;

   assign wr_en    = chipselect & write;
   assign tick_run = frame_tick & ~wr_en & (state_q == ST_RUN);

`ifdef PIPE_COLLIDE_EN
   logic hit_q, hit_d;
   logic unused_in;
   assign unused_in = hcount[0];
   assign move_en   = tick_run & ~hit_q;

   always_comb begin
      hit_d = hit_q;
      if (do_init)
         hit_d = 1'b0;
      else if (frame_tick && state_q != ST_RUN)
         hit_d = 1'b0;
      else if (state_q == ST_RUN && blank_n && bird_pix && pix)
         hit_d = 1'b1;
   end
`else
   logic unused_in;
   assign unused_in = ^{hcount[0], blank_n, bird_pix};
   assign move_en   = tick_run;
`endif

   always_comb begin
      lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      state_d   = state_q;
      score_d   = score_q;
      speed_d   = speed_q;
      xr_d      = xr_q;
      gap_top_d = gap_top_q;
      gap_h_d   = gap_h_q;
      do_init   = 1'b0;
      crossed   = 1'b0;
      r         = '0;
      left_old  = '0;
      left_new  = '0;
      bird_s    = $signed({3'd0, bird_x});

      if (wr_en) begin
         if (address == 3'd0) begin
            if (writedata[1]) begin
               do_init = 1'b1;
               state_d = ST_IDLE;
            end else if (writedata[0] && state_q != ST_RUN) begin
               do_init = 1'b1;
               state_d = ST_RUN;
            end
         end else if (address == 3'd1) begin
            speed_d = writedata[2:0];
         end
      end

`ifdef PIPE_COLLIDE_EN
      if (tick_run && hit_q)
         state_d = ST_HIT;
`endif

      if (move_en) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            if (xr_q[i] <= {9'd0, speed_q}) begin
               // Each pipe draws its new gap from a differently rotated LFSR view.
               r            = 16'({lfsr_q, lfsr_q} >> (16 - ((3 * i) % 16)));
               xr_d[i]      = xr_q[i] + 12'(NUM_PIPES * PIPE_SPACING) - {9'd0, speed_q};
               gap_top_d[i] = 10'(TOP_MIN) + 10'(r >> 8);
               gap_h_d[i]   = 10'(GAP_MIN) + 10'(r & 16'h003F);
            end else begin
               xr_d[i] = xr_q[i] - {9'd0, speed_q};
            end
            left_old = $signed({1'b0, xr_q[i]}) - PW13;
            left_new = $signed({1'b0, xr_d[i]}) - PW13;
            if (left_old > bird_s && left_new <= bird_s)
               crossed = 1'b1;
         end
         if (crossed && score_q != 16'hFFFF)
            score_d = score_q + 16'd1;
      end

      if (do_init) begin
         score_d = '0;
         for (int i = 0; i < NUM_PIPES; i++) begin
            xr_d[i]      = init_xr(i);
            gap_top_d[i] = init_gap_top(i);
            gap_h_d[i]   = 10'(GAP_MIN + 32);
         end
      end
   end

   always_comb begin
      pix     = 1'b0;
      px_left = '0;
      col_s   = $signed({3'd0, hcount[10:1]});
      for (int i = 0; i < NUM_PIPES; i++) begin
         px_left = $signed({1'b0, xr_q[i]}) - PW13;
         if (col_s >= px_left && {2'd0, hcount[10:1]} < xr_q[i] &&
             (vcount < gap_top_q[i] ||
              {1'b0, vcount} >= {1'b0, gap_top_q[i]} + {1'b0, gap_h_q[i]}))
            pix = 1'b1;
      end
   end

   always_comb begin
      readdata_d = readdata_q;
      if (chipselect && read) begin
         case (address)
            3'd0:    readdata_d = {6'd0, state_q};
            3'd1:    readdata_d = score_q[7:0];
            3'd2:    readdata_d = score_q[15:8];
            3'd3:    readdata_d = lfsr_q[7:0];
            default: readdata_d = 8'd0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         score_q    <= '0;
         speed_q    <= 3'd2;
         lfsr_q     <= 16'hACE1;
         readdata_q <= '0;
`ifdef PIPE_COLLIDE_EN
         hit_q      <= 1'b0;
`endif
         for (int i = 0; i < NUM_PIPES; i++) begin
            xr_q[i]      <= init_xr(i);
            gap_top_q[i] <= init_gap_top(i);
            gap_h_q[i]   <= 10'(GAP_MIN + 32);
         end
      end else begin
         state_q    <= state_d;
         score_q    <= score_d;
         speed_q    <= speed_d;
         lfsr_q     <= lfsr_d;
         readdata_q <= readdata_d;
`ifdef PIPE_COLLIDE_EN
         hit_q      <= hit_d;
`endif
         xr_q       <= xr_d;
         gap_top_q  <= gap_top_d;
         gap_h_q    <= gap_h_d;
      end
   end

   assign readdata = readdata_q;
   assign pipe_pix = pix;
   assign state    = state_q;
   assign score    = score_q;

endmodule

// File: doc/flappy_pipe_engine.md
# flappy_pipe_engine

Parametrised pipe-obstacle engine for the Flappy Bird VGA peripheral. Keeps NUM_PIPES scrolling pipe pairs with LFSR-randomised gaps, moves them once per frame under a small game FSM (IDLE/RUN/HIT), and produces a per-pixel pipe mask for the colour mux. It also detects bird/pipe pixel coincidence and keeps a score. Sits beside the VGA counters and the bird renderer, on the same Avalon slave bus.

## Interface
- NUM_PIPES, 3: pipe pairs; 1..8.
- PIPE_WIDTH, 70: pipe width in pixels.
- PIPE_SPACING, 250: right-edge distance between pipes; NUM_PIPES*PIPE_SPACING >= 640+PIPE_WIDTH.
- GAP_MIN, 120: minimum gap height; gap height = GAP_MIN + 0..63.
- TOP_MIN, 40: minimum gap top row; TOP_MIN+255+GAP_MIN+63 <= 480.
- clk  in  1  system clock (50 MHz). Single clock domain.
- reset  in  1  asynchronous, active-high reset.
- chipselect, write, read  in  1 each  Avalon slave strobes.
- address  in  3  register index.
- writedata  in  8  write data.
- readdata  out  8  read data, registered.
- hcount  in  11  from the VGA counters; pixel column = hcount[10:1].
- vcount  in  10  pixel row.
- blank_n  in  1  high during active video.
- frame_tick  in  1  one-cycle pulse at VS rising edge (vertical blanking).
- bird_x  in  10  bird column, used for scoring.
- bird_pix  in  1  current pixel belongs to the bird.
- pipe_pix  out  1  current pixel belongs to a pipe.
- state  out  2  0=IDLE, 1=RUN, 2=HIT.
- score  out  16  pipes passed.

## Operation
- Per pipe i: xr[i] (12 b, right edge, exclusive), gap_top[i] (10 b), gap_h[i] (7+ b). Pipe covers columns xr-PIPE_WIDTH .. xr-1 (signed compare, 13 b) and rows < gap_top or >= gap_top+gap_h.
- pipe_pix = OR over pipes. Combinational from hcount/vcount and the state registers.
- Init set, applied on reset, start, and stop:
  - xr[i] = 640+PIPE_WIDTH+i*PIPE_SPACING.
  - gap_top[i] = TOP_MIN+64*i mod 256.
  - gap_h[i] = GAP_MIN+32.
  - score = 0, hit_latch = 0.
- LFSR: 16 b Fibonacci, taps 16,14,13,11. Seed 16'hACE1. Steps every clk in every state, including reset release.
- Respawn value for pipe i uses r_i = LFSR rotated left by 3*i:
  - gap_top = TOP_MIN + r_i[15:8].
  - gap_h = GAP_MIN + r_i[5:0].
- Writes:
  - addr 0 control: bit0 start, bit1 stop. Stop wins if both are set.
  - addr 1 speed[2:0]: reset 2. Speed 0 freezes motion in RUN.
- Reads (1-cycle latency): 0 = {6'b0,state}, 1 = score[7:0], 2 = score[15:8], 3 = LFSR[7:0], others = 0.
- FSM:
  - IDLE: start → init, RUN.
  - RUN: on frame_tick, hit_latch=1 → HIT, no motion that frame. Otherwise every pipe does xr -= speed. If xr <= speed, respawn: xr = xr + NUM_PIPES*PIPE_SPACING - speed, with a new gap.
  - HIT: frozen. start → init, RUN.
  - Any state: stop → init, IDLE.
- Scoring: in RUN on frame_tick, a pipe with old xr-PIPE_WIDTH > bird_x and new xr-PIPE_WIDTH <= bird_x adds 1 to score. Score saturates at 16'hFFFF. At most one pipe crosses per frame.
- Collision: hit_latch sets when blank_n & bird_pix & pipe_pix while in RUN. It clears on init and on every frame_tick that is not in RUN.

## Timing
- Reset values: state=IDLE, score=0, readdata=0, speed=2, hit_latch=0, pipes at the init set. pipe_pix is 0 over all visible pixels because every left edge is >= 640.
- Pipe positions, gaps, score and state change only on a frame_tick cycle or on a control write. This keeps geometry frame-stable with no tearing.
- Control write takes effect the next cycle.
- Write and frame_tick in the same cycle: the write wins and the frame update is skipped.
- hit_latch set in the same cycle as frame_tick is evaluated at the next frame_tick.
- Async reset mid-frame: all state returns to reset values immediately. LFSR restarts from the seed.

## Configuration
- PIPE_COLLIDE_EN defined: hit_latch and the RUN→HIT transition exist as specified.
- PIPE_COLLIDE_EN undefined: no collision logic is built, bird_pix is ignored, and HIT is unreachable (state never reads 2). Scoring and motion are unchanged.

## Test plan
- Reset, then read addrs 0/1/2 → 0, 0, 0. pipe_pix=0 over a full frame. speed=2.
- Write start, then 1 frame_tick → state=1 and xr[0]=708 (pipe 0 left edge at column 638). pipe_pix=1 at column 639 outside the gap.
- RUN at speed 7 with xr[0]=5 → after the tick, xr[0]=3*250+5-7=748. gap_top lies in 40..295 and gap_h lies in 120..183.
- bird_x=100, pipe 0 left edge=101, speed 2 → after 1 tick score=1. Score stays 1 on the next tick.
- PIPE_COLLIDE_EN: drive bird_pix=1 on a pipe pixel with blank_n=1 → at the next tick state=2 and xr unchanged. Start → RUN with score=0. With the macro undefined, same stimulus → state stays 1.
- Write ctrl=8'h03 while in RUN → state=0 and the init set is restored. A frame_tick in the same cycle causes no motion.
